fpga_program_runner: RTL and testbench

Parametrised program-execution core for the FPGA test flow: holds a loaded program in an instruction memory, executes it against a local data memory and streams results out on a valid/ready channel. It replaces the per-test, hard-wired instruction case statements with one reusable engine. It adds a load port, output backpressure, conditional jumps, and a step-limit timeout that drives `finished`/`success`.

---
 rtl/fpga_runner_pkg.sv | 50 +++++
 rtl/runner_alu.sv | 24 ++
 rtl/fpga_program_runner.sv | 165 ++++++++++++++++
 tb/tb_fpga_program_runner.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_runner_pkg.sv
// Shared definitions for the program runner: opcode and FSM state
// encodings, plus instruction field offsets derived from the data
// width (w) and the local-memory address width (aw).
// Instruction layout, LSB first:
//   opcode[3:0], T[aw-1:0], A[w-1:0], immA, B[w-1:0], immB
package fpga_runner_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_MOV  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_OUT  = 4'd4,
        OP_JEQ  = 4'd5,
        OP_JLT  = 4'd6,
        OP_HALT = 4'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_OUTWAIT,
        ST_DONE
    } state_e;

    localparam int unsigned OpcodeWidth = 4;
    localparam int unsigned OffT        = OpcodeWidth;

    function automatic int unsigned off_a(input int unsigned aw);
        return OffT + aw;
    endfunction

    function automatic int unsigned off_ia(input int unsigned w, input int unsigned aw);
        return off_a(aw) + w;
    endfunction

    function automatic int unsigned off_b(input int unsigned w, input int unsigned aw);
        return off_ia(w, aw) + 1;
    endfunction

    function automatic int unsigned off_ib(input int unsigned w, input int unsigned aw);
        return off_b(w, aw) + w;
    endfunction

    function automatic int unsigned instr_width(input int unsigned w, input int unsigned aw);
        return off_ib(w, aw) + 1;
    endfunction

endpackage

// File: rtl/runner_alu.sv
// Combinational operand unit for the program runner.
// Ports:
//   i_a, i_b  : operand values (W bits)
//   o_sum     : i_a + i_b modulo 2^W
//   o_diff    : i_a - i_b modulo 2^W (wraps, 0-1 = all ones)
//   o_eq      : i_a == i_b
//   o_lt      : i_a <  i_b, unsigned
module runner_alu #(
    parameter int unsigned W = 12
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_diff,
    output logic         o_eq,
    output logic         o_lt
);

    assign o_sum  = i_a + i_b;
    assign o_diff = i_a - i_b;
    assign o_eq   = (i_a == i_b);
    assign o_lt   = (i_a < i_b);

endmodule

// File: rtl/fpga_program_runner.sv
// Program-execution core: holds a loaded program, runs it against a local
// data memory and streams OUT results on a valid/ready channel.
// Ports:
//   clock, reset_n        : clock (posedge) and async active-low reset
//   load_valid/addr/data  : program slot write, honoured only when idle/done
//   run                   : one-cycle start pulse, honoured only when idle/done
//   out_valid/data/ready  : result stream, data held until transfer
//   finished, success     : program ended; 1 = clean halt, 0 = step timeout
//   steps                 : instructions executed since last run
module fpga_program_runner
    import fpga_runner_pkg::*;
#(
    parameter int unsigned MemoryElementWidth = 12,
    parameter int unsigned NLocal             = 64,
    parameter int unsigned NProgram           = 32,
    parameter int unsigned MaxSteps           = 1000,
    localparam int unsigned W          = MemoryElementWidth,
    localparam int unsigned AW         = $clog2(NLocal),
    localparam int unsigned PW         = $clog2(NProgram),
    localparam int unsigned InstrWidth = instr_width(W, AW)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load_valid,
    input  logic [PW-1:0]         load_addr,
    input  logic [InstrWidth-1:0] load_data,
    input  logic                  run,
    output logic                  out_valid,
    output logic [W-1:0]          out_data,
    input  logic                  out_ready,
    output logic                  finished,
    output logic                  success,
    output logic [31:0]           steps
);

    localparam int unsigned OffA  = off_a(AW);
    localparam int unsigned OffIA = off_ia(W, AW);
    localparam int unsigned OffB  = off_b(W, AW);
    localparam int unsigned OffIB = off_ib(W, AW);

    // ip carries one extra bit so running off the end is detectable.
    localparam logic [PW:0] IpLimit = (PW+1)'(NProgram);
    localparam logic [InstrWidth-1:0] HaltInstr = {{(InstrWidth-OpcodeWidth){1'b0}}, OP_HALT};

    state_e                r_state;
    state_e                w_next;
    logic [PW:0]           r_ip;
    logic [31:0]           r_steps;
    logic [InstrWidth-1:0] r_instr;
    logic [W-1:0]          r_out_data;
    logic                  r_success;

    logic [InstrWidth-1:0] r_prog [NProgram];
    logic [W-1:0]          r_mem  [NLocal];

    logic [3:0]    w_op;
    logic [AW-1:0] w_t;
    logic [W-1:0]  w_fa, w_fb, w_a, w_b;
    logic [W-1:0]  w_sum, w_diff, w_wdata;
    logic          w_eq, w_lt, w_we, w_jump;
    logic          w_idle_like;
    logic [31:0]   w_steps_inc;
    logic          w_limit;

    assign w_op = r_instr[OpcodeWidth-1:0];
    assign w_t  = r_instr[OffA-1:OffT];
    assign w_fa = r_instr[OffIA-1:OffA];
    assign w_fb = r_instr[OffIB-1:OffB];
    assign w_a  = r_instr[OffIA] ? w_fa : r_mem[w_fa[AW-1:0]];
    assign w_b  = r_instr[OffIB] ? w_fb : r_mem[w_fb[AW-1:0]];

    runner_alu #(.W(W)) u_alu (
        .i_a    (w_a),
        .i_b    (w_b),
        .o_sum  (w_sum),
        .o_diff (w_diff),
        .o_eq   (w_eq),
        .o_lt   (w_lt)
    );

    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_steps_inc = r_steps + 32'd1;
    assign w_limit     = (w_steps_inc == MaxSteps);

    always_comb begin
        w_we    = 1'b0;
        w_wdata = w_a;
        w_jump  = 1'b0;
        if (r_state == ST_EXEC) begin
            case (w_op)
                OP_MOV:  begin w_we = 1'b1; w_wdata = w_a;    end
                OP_ADD:  begin w_we = 1'b1; w_wdata = w_sum;  end
                OP_SUB:  begin w_we = 1'b1; w_wdata = w_diff; end
                OP_JEQ:  w_jump = w_eq;
                OP_JLT:  w_jump = w_lt;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (run) w_next = ST_FETCH;
            ST_FETCH:         w_next = ST_EXEC;
            ST_EXEC: begin
                if (w_op == OP_HALT)     w_next = ST_DONE;
                else if (w_op == OP_OUT) w_next = ST_OUTWAIT;
                else if (w_limit)        w_next = ST_DONE;
                else                     w_next = ST_FETCH;
            end
            // A timeout reached on an OUT step is deferred until the word is taken.
            ST_OUTWAIT: if (out_ready) w_next = (r_steps == MaxSteps) ? ST_DONE : ST_FETCH;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ip       <= '0;
            r_steps    <= '0;
            r_instr    <= '0;
            r_out_data <= '0;
            r_success  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (run) begin
                        r_ip      <= '0;
                        r_steps   <= '0;
                        r_success <= 1'b0;
                    end
                end
                ST_FETCH: r_instr <= (r_ip >= IpLimit) ? HaltInstr : r_prog[r_ip[PW-1:0]];
                ST_EXEC: begin
                    r_steps <= w_steps_inc;
                    r_ip    <= w_jump ? {1'b0, w_t[PW-1:0]} : r_ip + 1'b1;
                    if (w_op == OP_HALT) r_success  <= 1'b1;
                    if (w_op == OP_OUT)  r_out_data <= w_a;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (load_valid && w_idle_like) r_prog[load_addr] <= load_data;
    end

    always_ff @(posedge clock) begin
        if (w_we) r_mem[w_t] <= w_wdata;
    end

    assign out_valid = (r_state == ST_OUTWAIT);
    assign out_data  = r_out_data;
    assign finished  = (r_state == ST_DONE);
    assign success   = r_success;
    assign steps     = r_steps;

endmodule

// File: tb/tb_fpga_program_runner.sv
module tb_fpga_program_runner;

    localparam int W    = 12;
    localparam int PW   = 5;
    localparam int IW   = 36;
    localparam int NP   = 32;
    localparam int MAXS = 20;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          load_valid = 1'b0;
    logic [PW-1:0] load_addr = '0;
    logic [IW-1:0] load_data = '0;
    logic          run = 1'b0;
    logic          out_ready = 1'b1;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          finished;
    logic          success;
    logic [31:0]   steps;

    int vectors = 0;
    int miscompares = 0;
    int rdy_mode = 0;

    logic [W-1:0]  exp_q[$];
    logic [IW-1:0] img[NP];
    logic [W-1:0]  mem_m[64];
    logic [IW-1:0] halt_i = 36'd7;

    fpga_program_runner #(
        .MemoryElementWidth (12),
        .NLocal             (64),
        .NProgram           (32),
        .MaxSteps           (MAXS)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .run        (run),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .finished   (finished),
        .success    (success),
        .steps      (steps)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [5:0] t,
                                         input logic [11:0] a, input logic ia,
                                         input logic [11:0] b, input logic ib);
        return {ib, b, ia, a, t, op};
    endfunction

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rdy_mode == 0)      out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops expected words on each transfer and checks that a
    // stalled word stays valid and unchanged.
    logic         pv = 1'b0;
    logic         pt = 1'b0;
    logic [W-1:0] pd = '0;
    always @(negedge clock) begin
        if (!reset_n) begin
            pv = 1'b0;
        end else begin
            if (pv && !pt) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(pd));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_out: got %0h expected no word", out_data);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
            pv = out_valid;
            pt = out_valid && out_ready;
            pd = out_data;
        end
    end

    // Behavioural interpreter of the program image.
    task automatic model_run(output int st, output bit ok);
        int ip = 0;
        logic [IW-1:0] ins;
        logic [3:0] op;
        logic [5:0] t;
        logic [W-1:0] av, bv;
        bit jmp;
        st = 0;
        ok = 0;
        while (1) begin
            ins = (ip >= NP) ? halt_i : img[ip];
            op  = ins[3:0];
            t   = ins[9:4];
            av  = ins[22] ? ins[21:10] : mem_m[ins[15:10]];
            bv  = ins[35] ? ins[34:23] : mem_m[ins[28:23]];
            st++;
            jmp = 0;
            case (op)
                4'd1: mem_m[t] = av;
                4'd2: mem_m[t] = av + bv;
                4'd3: mem_m[t] = av - bv;
                4'd4: exp_q.push_back(av);
                4'd5: if (av == bv) begin ip = int'(t[4:0]); jmp = 1; end
                4'd6: if (av < bv)  begin ip = int'(t[4:0]); jmp = 1; end
                4'd7: begin ok = 1; return; end
                default: ;
            endcase
            if (!jmp) ip++;
            if (st == MAXS) return;
        end
    endtask

    int exp_st;
    bit exp_ok;

    // Loads slots 31..1, then slot 0 together with run; the following cycle
    // tries to overwrite slot 1 with HALT while executing, which must be ignored.
    task automatic start_run();
        model_run(exp_st, exp_ok);
        for (int s = NP - 1; s >= 1; s--) begin
            load_valid = 1'b1;
            load_addr  = PW'(s);
            load_data  = img[s];
            @(posedge clock); #1;
        end
        load_addr = '0;
        load_data = img[0];
        run = 1'b1;
        @(posedge clock); #1;
        run = 1'b0;
        load_addr = 5'd1;
        load_data = halt_i;
        @(posedge clock); #1;
        load_valid = 1'b0;
    endtask

    task automatic finish_run(input string name);
        int n = 0;
        while (!finished && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (!finished) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: finished stayed 0 for %0d cycles, expected 1", name, n);
        end
        check({name, "_steps"}, steps, 32'(exp_st));
        check({name, "_success"}, 32'(success), 32'(exp_ok));
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic clear_img();
        for (int s = 0; s < NP; s++) img[s] = halt_i;
    endtask

    task automatic load_loop();
        clear_img();
        img[0] = mk(4'd1, 6'd0, 12'd0, 1'b1, 12'd0, 1'b0);
        img[1] = mk(4'd4, 6'd0, 12'd0, 1'b0, 12'd0, 1'b0);
        img[2] = mk(4'd2, 6'd0, 12'd0, 1'b0, 12'd1, 1'b1);
        img[3] = mk(4'd6, 6'd1, 12'd0, 1'b0, 12'd4, 1'b1);
    endtask

    task automatic gen_random();
        int len;
        logic [3:0] op;
        logic [5:0] t;
        logic ia, ib;
        logic [11:0] a, b;
        len = $urandom_range(6, 32);
        clear_img();
        for (int s = 0; s < 4; s++) img[s] = mk(4'd1, 6'(s), 12'($urandom), 1'b1, 12'd0, 1'b0);
        for (int s = 4; s < len; s++) begin
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
            t  = (op == 4'd5 || op == 4'd6) ? 6'($urandom) : 6'($urandom_range(0, 3));
            ia = 1'($urandom_range(0, 1));
            ib = 1'($urandom_range(0, 1));
            a  = ia ? 12'($urandom) : ((12'($urandom) & 12'hFC0) | 12'($urandom_range(0, 3)));
            b  = ib ? 12'($urandom) : ((12'($urandom) & 12'hFC0) | 12'($urandom_range(0, 3)));
            img[s] = mk(op, t, a, ia, b, ib);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_m[i] = '0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_finished", 32'(finished), 32'd0);
        check("rst_success", 32'(success), 32'd0);
        check("rst_steps", steps, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        rdy_mode = 0;
        clear_img();
        img[0] = mk(4'd3, 6'd0, 12'd4, 1'b1, 12'd2, 1'b1);
        img[1] = mk(4'd4, 6'd0, 12'd0, 1'b0, 12'd0, 1'b0);
        start_run();
        finish_run("sub_out");

        img[0] = mk(4'd3, 6'd0, 12'd0, 1'b1, 12'd1, 1'b1);
        start_run();
        finish_run("sub_wrap");

        rdy_mode = 2;
        out_ready = 1'b0;
        img[0] = mk(4'd3, 6'd0, 12'd4, 1'b1, 12'd2, 1'b1);
        start_run();
        for (int n = 0; n < 100 && !out_valid; n++) @(negedge clock);
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        repeat (5) begin @(posedge clock); #1; end
        out_ready = 1'b1;
        finish_run("backpressure");

        rdy_mode = 0;
        load_loop();
        start_run();
        finish_run("loop");

        clear_img();
        img[0] = mk(4'd5, 6'd0, 12'd0, 1'b1, 12'd0, 1'b1);
        start_run();
        finish_run("jeq_timeout");

        clear_img();
        img[1] = mk(4'd4, 6'd0, 12'hABC, 1'b1, 12'd0, 1'b0);
        img[2] = mk(4'd5, 6'd1, 12'd0, 1'b1, 12'd0, 1'b1);
        img[0] = mk(4'd0, 6'd0, 12'd0, 1'b0, 12'd0, 1'b0);
        rdy_mode = 1;
        start_run();
        finish_run("out_timeout");

        for (int r = 0; r < 20; r++) begin
            gen_random();
            start_run();
            finish_run("random");
        end

        load_loop();
        start_run();
        repeat (9) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_finished", 32'(finished), 32'd0);
        check("midrst_success", 32'(success), 32'd0);
        check("midrst_steps", steps, 32'd0);
        exp_q.delete();
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        start_run();
        finish_run("rerun");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
